// File: rtl/adrv9001_axil_pkg.sv
// Shared definitions for the ADRV9001 AXI4-Lite master: FSM state encoding,
// AXI response codes and the default response timeout.
package adrv9001_axil_pkg;

    // One outstanding transaction: the FSM walks one command through its
    // address/data phase, its response wait, and the response hand-back.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WRITE  = 3'd1,
        ST_WAIT_B = 3'd2,
        ST_READ   = 3'd3,
        ST_WAIT_R = 3'd4,
        ST_RESP   = 3'd5
    } axil_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int DEFAULT_TIMEOUT = 1024;

    // Width of the timeout counter; at least one bit so a disabled timeout
    // (0) still elaborates to a legal vector.
    function automatic int cnt_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/adrv9001_axil_timeout.sv
// Response timeout counter: cleared outside the response-wait states,
// counts while enabled, saturates instead of wrapping, and flags the
// terminal count TIMEOUT-1. TIMEOUT=0 disables expiry entirely.
module adrv9001_axil_timeout
    import adrv9001_axil_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int              CW   = cnt_width(TIMEOUT);
    localparam logic [CW-1:0]   TERM = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [CW-1:0]   SAT  = '1;

    logic [CW-1:0] count;

    // Count wait cycles; hold at all-ones rather than wrapping back to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != SAT)) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (TIMEOUT > 0) && enable && (count == TERM);

endmodule

// File: rtl/adrv9001_axil_master.sv
// AXI4-Lite initiator for the ADRV9001 register block. Accepts one register
// command at a time on a valid/ready stream, runs it as a single AXI4-Lite
// write or read, and hands back exactly one response per command. A missing
// B/R beat is converted into a SLVERR response after TIMEOUT wait cycles.
//
// Handshake rule used on every stream here (cmd, rsp and all AXI channels):
// a beat transfers on a rising clock edge where valid and ready are both 1;
// a source never drops valid before that edge and keeps its payload stable
// while valid is high; ready may be high with or without valid.
module adrv9001_axil_master
    import adrv9001_axil_pkg::*;
#(
    parameter int ADDR_WIDTH = 7,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic                  m_axi_aclk,
    input  logic                  m_axi_areset,

    // Command stream
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]           cmd_wdata,
    input  logic [3:0]            cmd_wstrb,

    // Response stream
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [31:0]           rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_timeout,

    // AXI4-Lite write address channel
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [2:0]            m_axi_awprot,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,

    // AXI4-Lite write data channel
    output logic [31:0]           m_axi_wdata,
    output logic [3:0]            m_axi_wstrb,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,

    // AXI4-Lite write response channel
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,

    // AXI4-Lite read address channel
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,

    // AXI4-Lite read data channel
    input  logic [31:0]           m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,

    // Current FSM state, for observation only
    output logic [2:0]            dbg_state
);

    axil_state_t state;
    logic        run_q;
    logic        aw_done;
    logic        w_done;
    logic        tmo_clear;
    logic        tmo_enable;
    logic        tmo_expired;

    // Unprivileged, secure, data access on every transaction.
    assign m_axi_awprot = 3'b000;
    assign m_axi_arprot = 3'b000;

    // Ready outputs are decoded from registers only. B and R are always
    // accepted once out of reset so that a response arriving after a timeout
    // is drained instead of stalling the slave.
    assign cmd_ready    = run_q && (state == ST_IDLE);
    assign m_axi_bready = run_q;
    assign m_axi_rready = run_q;

    assign dbg_state = state;

    // A write channel is finished when it has already handshaken (valid
    // dropped) or handshakes on this edge.
    assign aw_done = !m_axi_awvalid || m_axi_awready;
    assign w_done  = !m_axi_wvalid  || m_axi_wready;

    assign tmo_enable = (state == ST_WAIT_B) || (state == ST_WAIT_R);
    assign tmo_clear  = !tmo_enable;

    adrv9001_axil_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (m_axi_aclk),
        .rst     (m_axi_areset),
        .clear   (tmo_clear),
        .enable  (tmo_enable),
        .expired (tmo_expired)
    );

    // Hold all ready outputs low through reset and release them on the first
    // clock edge after reset deasserts.
    always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
        if (m_axi_areset) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    // Command sequencer: one transaction in flight, all outputs registered.
    always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
        if (m_axi_areset) begin
            state         <= ST_IDLE;
            m_axi_awaddr  <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wdata   <= '0;
            m_axi_wstrb   <= '0;
            m_axi_wvalid  <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arvalid <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_write     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= RESP_OKAY;
            rsp_timeout   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        rsp_write <= cmd_write;
                        if (cmd_write) begin
                            m_axi_awaddr  <= cmd_addr;
                            m_axi_wdata   <= cmd_wdata;
                            m_axi_wstrb   <= cmd_wstrb;
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                            state         <= ST_WRITE;
                        end else begin
                            m_axi_araddr  <= cmd_addr;
                            m_axi_arvalid <= 1'b1;
                            state         <= ST_READ;
                        end
                    end
                end

                // AW and W retire independently, in either order.
                ST_WRITE: begin
                    if (m_axi_awvalid && m_axi_awready) begin
                        m_axi_awvalid <= 1'b0;
                    end
                    if (m_axi_wvalid && m_axi_wready) begin
                        m_axi_wvalid <= 1'b0;
                    end
                    if (aw_done && w_done) begin
                        state <= ST_WAIT_B;
                    end
                end

                // A real B beat wins over a timeout in the same cycle.
                ST_WAIT_B: begin
                    if (m_axi_bvalid) begin
                        rsp_resp    <= m_axi_bresp;
                        rsp_rdata   <= '0;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        state       <= ST_RESP;
                    end else if (tmo_expired) begin
                        rsp_resp    <= RESP_SLVERR;
                        rsp_rdata   <= '0;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= 1'b1;
                        state       <= ST_RESP;
                    end
                end

                ST_READ: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        state         <= ST_WAIT_R;
                    end
                end

                ST_WAIT_R: begin
                    if (m_axi_rvalid) begin
                        rsp_resp    <= m_axi_rresp;
                        rsp_rdata   <= m_axi_rdata;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        state       <= ST_RESP;
                    end else if (tmo_expired) begin
                        rsp_resp    <= RESP_SLVERR;
                        rsp_rdata   <= '0;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= 1'b1;
                        state       <= ST_RESP;
                    end
                end

                // Response fields stay frozen until the consumer takes them.
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adrv9001_axil_master.sv
// Self-checking bench for adrv9001_axil_master: a behavioural AXI4-Lite
// memory slave with per-channel ready/response delays, directed scenarios
// and a randomized command run checked against a word-array reference model.
module tb_adrv9001_axil_master;

  localparam int AW = 7;
  localparam int T  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [31:0]   cmd_wdata = '0;
  logic [3:0]    cmd_wstrb = '0;
  logic          rsp_valid, rsp_ready = 1'b0, rsp_write, rsp_timeout;
  logic [31:0]   rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
  logic [2:0]    m_axi_awprot, m_axi_arprot;
  logic          m_axi_awvalid, m_axi_awready;
  logic [31:0]   m_axi_wdata;
  logic [3:0]    m_axi_wstrb;
  logic          m_axi_wvalid, m_axi_wready;
  logic [1:0]    m_axi_bresp;
  logic          m_axi_bvalid, m_axi_bready;
  logic          m_axi_arvalid, m_axi_arready;
  logic [31:0]   m_axi_rdata;
  logic [1:0]    m_axi_rresp;
  logic          m_axi_rvalid, m_axi_rready;
  logic [2:0]    dbg_state;

  adrv9001_axil_master #(.ADDR_WIDTH(AW), .TIMEOUT(T)) dut (
    .m_axi_aclk(clk), .m_axi_areset(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  // ---------------- slave model ----------------
  int          aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
  logic        r_drop = 1'b0;
  logic [1:0]  slv_resp = 2'b00;
  logic [31:0] slv_mem [32] = '{default: '0};
  logic        aw_pend = 1'b0, w_pend = 1'b0, ar_pend = 1'b0;
  logic [AW-1:0] cap_awaddr = '0, cap_araddr = '0;
  logic [31:0] cap_wdata = '0;
  logic [3:0]  cap_wstrb = '0;
  int          aw_beats = 0, w_beats = 0, ar_beats = 0, b_beats = 0, r_beats = 0;

  initial begin : slave_aw
    m_axi_awready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (m_axi_awvalid) begin
        repeat (aw_delay) begin @(posedge clk); #1; end
        m_axi_awready = 1'b1;
        cap_awaddr = m_axi_awaddr;
        @(posedge clk); #1;
        m_axi_awready = 1'b0;
        aw_beats++;
        aw_pend = 1'b1;
      end
    end
  end

  initial begin : slave_w
    m_axi_wready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (m_axi_wvalid) begin
        repeat (w_delay) begin @(posedge clk); #1; end
        m_axi_wready = 1'b1;
        cap_wdata = m_axi_wdata;
        cap_wstrb = m_axi_wstrb;
        @(posedge clk); #1;
        m_axi_wready = 1'b0;
        w_beats++;
        w_pend = 1'b1;
      end
    end
  end

  initial begin : slave_b
    logic ok;
    m_axi_bvalid = 1'b0;
    m_axi_bresp  = 2'b00;
    forever begin
      @(posedge clk); #2;
      if (aw_pend && w_pend) begin
        aw_pend = 1'b0;
        w_pend  = 1'b0;
        for (int i = 0; i < 4; i++)
          if (cap_wstrb[i]) slv_mem[cap_awaddr[6:2]][8*i +: 8] = cap_wdata[8*i +: 8];
        repeat (b_delay) begin @(posedge clk); #2; end
        m_axi_bvalid = 1'b1;
        m_axi_bresp  = slv_resp;
        ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
          ok = m_axi_bready;
          @(posedge clk); #2;
        end
        m_axi_bvalid = 1'b0;
        m_axi_bresp  = 2'b00;
        b_beats++;
      end
    end
  end

  initial begin : slave_ar
    m_axi_arready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (m_axi_arvalid) begin
        repeat (ar_delay) begin @(posedge clk); #1; end
        m_axi_arready = 1'b1;
        cap_araddr = m_axi_araddr;
        @(posedge clk); #1;
        m_axi_arready = 1'b0;
        ar_beats++;
        ar_pend = 1'b1;
      end
    end
  end

  initial begin : slave_r
    logic ok;
    m_axi_rvalid = 1'b0;
    m_axi_rresp  = 2'b00;
    m_axi_rdata  = '0;
    forever begin
      @(posedge clk); #2;
      if (ar_pend) begin
        ar_pend = 1'b0;
        if (!r_drop) begin
          repeat (r_delay) begin @(posedge clk); #2; end
          m_axi_rvalid = 1'b1;
          m_axi_rresp  = slv_resp;
          m_axi_rdata  = slv_mem[cap_araddr[6:2]];
          ok = 1'b0;
          for (int k = 0; k < 200 && !ok; k++) begin
            ok = m_axi_rready;
            @(posedge clk); #2;
          end
          m_axi_rvalid = 1'b0;
          m_axi_rresp  = 2'b00;
          m_axi_rdata  = '0;
          r_beats++;
        end
      end
    end
  end

  // ---------------- scoreboard / reference model ----------------
  int          n_vec = 0, n_err = 0;
  logic [31:0] ref_mem [32] = '{default: '0};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One command end to end. Expected response and latency come from the
  // cycle rules: accept edge A; address phase done max(aw,w)/ar delay + 1
  // edges later; response beat d_r + 1 edges after that, unless d_r reaches
  // the timeout window, in which case SLVERR arrives T edges after it.
  task automatic txn(input string tag, input logic wr, input logic [AW-1:0] addr,
                     input logic [31:0] data, input logic [3:0] strb,
                     input int d_a, input int d_w, input int d_r,
                     input logic [1:0] resp, input int hold);
    int          acc, rc, lat, addr_phase, aw0, w0, ar0;
    logic        exp_tmo, stable;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    logic [35:0] snap;
    aw_delay = d_a; w_delay = d_w; ar_delay = d_a;
    b_delay = d_r; r_delay = d_r; slv_resp = resp;

    addr_phase = wr ? ((d_a > d_w) ? d_a : d_w) : d_a;
    exp_tmo    = (d_r >= T);
    lat        = exp_tmo ? (1 + addr_phase + T) : (2 + addr_phase + d_r);
    exp_resp   = exp_tmo ? 2'b10 : resp;
    exp_rdata  = (wr || exp_tmo) ? 32'h0 : ref_mem[addr[6:2]];
    if (wr)
      for (int i = 0; i < 4; i++)
        if (strb[i]) ref_mem[addr[6:2]][8*i +: 8] = data[8*i +: 8];

    aw0 = aw_beats; w0 = w_beats; ar0 = ar_beats;
    cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
    cmd_valid = 1'b1;
    acc = -1;
    for (int k = 0; k < 50 && acc < 0; k++) begin
      if (cmd_ready) acc = cyc + 1;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom_range(0, 1));
    cmd_addr  = AW'($urandom_range(0, 127));
    cmd_wdata = $urandom;
    cmd_wstrb = 4'($urandom_range(0, 15));
    chk({tag, ".accepted"}, 64'(acc >= 0), 64'(1));

    rc = -1;
    for (int k = 0; k < 100 && rc < 0; k++) begin
      if (rsp_valid) rc = cyc;
      else begin @(posedge clk); #1; end
    end
    chk({tag, ".rsp_seen"}, 64'(rc >= 0), 64'(1));
    chk({tag, ".latency"}, 64'(rc - acc), 64'(lat));
    chk({tag, ".rsp_write"}, 64'(rsp_write), 64'(wr));
    chk({tag, ".rsp_resp"}, 64'(rsp_resp), 64'(exp_resp));
    chk({tag, ".rsp_rdata"}, 64'(rsp_rdata), 64'(exp_rdata));
    chk({tag, ".rsp_timeout"}, 64'(rsp_timeout), 64'(exp_tmo));

    snap = {rsp_write, rsp_resp, rsp_timeout, rsp_rdata};
    stable = 1'b1;
    repeat (hold) begin
      @(posedge clk); #1;
      if (!rsp_valid || cmd_ready || ({rsp_write, rsp_resp, rsp_timeout, rsp_rdata} !== snap))
        stable = 1'b0;
    end
    if (hold > 0) chk({tag, ".hold_stable"}, 64'(stable), 64'(1));
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, ".rsp_dropped"}, 64'(rsp_valid), 64'(0));
    chk({tag, ".cmd_ready_next"}, 64'(cmd_ready), 64'(1));

    chk({tag, ".aw_beats"}, 64'(aw_beats - aw0), 64'(wr));
    chk({tag, ".w_beats"}, 64'(w_beats - w0), 64'(wr));
    chk({tag, ".ar_beats"}, 64'(ar_beats - ar0), 64'(!wr));
    if (wr) begin
      chk({tag, ".awaddr"}, 64'(cap_awaddr), 64'(addr));
      chk({tag, ".wdata"}, 64'(cap_wdata), 64'(data));
      chk({tag, ".wstrb"}, 64'(cap_wstrb), 64'(strb));
    end else begin
      chk({tag, ".araddr"}, 64'(cap_araddr), 64'(addr));
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin : main
    int   b0, ar0, acc;
    logic quiet;

    // reset
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.valids", 64'({cmd_ready, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, rsp_valid}), 64'(0));
    chk("reset.readies", 64'({m_axi_bready, m_axi_rready}), 64'(0));
    chk("reset.rsp_fields", 64'({rsp_write, rsp_timeout, rsp_resp, rsp_rdata}), 64'(0));
    chk("reset.payload", 64'({m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_wstrb}), 64'(0));
    chk("reset.prot", 64'({m_axi_awprot, m_axi_arprot}), 64'(0));
    rst = 1'b0;
    #1;
    chk("reset.cmd_ready_before_edge", 64'(cmd_ready), 64'(0));
    @(posedge clk); #1;
    chk("reset.cmd_ready_after", 64'(cmd_ready), 64'(1));
    chk("reset.b_r_ready_after", 64'({m_axi_bready, m_axi_rready}), 64'(2'b11));

    // basic write / read-back with a one-cycle-late slave
    txn("wr3c", 1'b1, 7'h3C, 32'h12345678, 4'hF, 1, 1, 0, 2'b00, 0);
    txn("rd3c", 1'b0, 7'h3C, 32'h0, 4'h0, 1, 1, 0, 2'b00, 0);
    txn("wr7c", 1'b1, 7'h7C, 32'h12345678, 4'hF, 1, 1, 0, 2'b00, 0);
    txn("rd7c", 1'b0, 7'h7C, 32'h0, 4'h0, 1, 1, 0, 2'b00, 0);

    // partial strobes and a non-OKAY slave response
    txn("wr_strb", 1'b1, 7'h3C, 32'hA5A5C3C3, 4'b0101, 0, 0, 0, 2'b01, 0);
    txn("rd_strb", 1'b0, 7'h3C, 32'h0, 4'h0, 0, 0, 2, 2'b11, 0);

    // W completes 3 cycles before AW, then the reverse
    txn("aw_late", 1'b1, 7'h10, 32'hDEADBEEF, 4'hF, 3, 0, 0, 2'b00, 0);
    txn("w_late", 1'b1, 7'h14, 32'hCAFEF00D, 4'hF, 0, 3, 1, 2'b00, 0);
    txn("rd_order", 1'b0, 7'h10, 32'h0, 4'h0, 2, 0, 0, 2'b00, 0);

    // B never arrives within the window; the late B is drained in IDLE
    b0 = b_beats;
    txn("tmo", 1'b1, 7'h20, 32'h0BADF00D, 4'hF, 0, 0, 30, 2'b00, 0);
    quiet = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (rsp_valid) quiet = 1'b0;
    end
    chk("tmo.late_b_absorbed", 64'(b_beats - b0), 64'(1));
    chk("tmo.no_second_rsp", 64'(quiet), 64'(1));

    // consumer back-pressure for 10 cycles
    txn("hold10", 1'b0, 7'h20, 32'h0, 4'h0, 1, 1, 1, 2'b00, 10);

    // reset while waiting for R
    r_drop = 1'b1; ar_delay = 0; slv_resp = 2'b00;
    ar0 = ar_beats;
    cmd_write = 1'b0; cmd_addr = 7'h3C; cmd_valid = 1'b1;
    acc = -1;
    for (int k = 0; k < 50 && acc < 0; k++) begin
      if (cmd_ready) acc = cyc + 1;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    for (int k = 0; k < 20 && ar_beats == ar0; k++) begin @(posedge clk); #1; end
    chk("rst_wait_r.ar_done", 64'(ar_beats - ar0), 64'(1));
    repeat (2) begin @(posedge clk); #1; end
    chk("rst_wait_r.no_rsp_yet", 64'(rsp_valid), 64'(0));
    rst = 1'b1;
    #1;
    chk("rst_wait_r.valids_low", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, rsp_valid}), 64'(0));
    chk("rst_wait_r.readies_low", 64'({cmd_ready, m_axi_bready, m_axi_rready}), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    r_drop = 1'b0;
    #1;
    chk("rst_wait_r.cmd_ready_held", 64'(cmd_ready), 64'(0));
    @(posedge clk); #1;
    chk("rst_wait_r.cmd_ready_back", 64'(cmd_ready), 64'(1));
    chk("rst_wait_r.rsp_clear", 64'({rsp_valid, rsp_timeout, rsp_resp, rsp_rdata}), 64'(0));
    txn("after_rst", 1'b0, 7'h3C, 32'h0, 4'h0, 1, 1, 0, 2'b00, 0);

    // randomized commands
    for (int n = 0; n < 40; n++) begin
      txn($sformatf("rand%0d", n), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 127)),
          $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 3), 2'($urandom_range(0, 3)), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
